// File: rtl/data_sram_pkg.sv
// Shared constants and the word type for the 128x8 data SRAM.
package data_sram_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 7;
  localparam int DEPTH  = 2 ** ADDR_W;

  typedef logic [DATA_W-1:0] word_t;

endpackage : data_sram_pkg

// File: rtl/data_sram_mem.sv
// Storage array with a single synchronous write port and an asynchronous read tap.
// DATA_SRAM_CLR_EN: when defined, reset also clears every word to zero.
module data_sram_mem #(
  parameter int DATA_W = data_sram_pkg::DATA_W,
  parameter int ADDR_W = data_sram_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              wr_en;

  // Writes are dropped while reset is held, whether or not the array is cleared.
  assign wr_en = we_i & rst_n;

`ifdef DATA_SRAM_CLR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[addr_i] <= wdata_i;
    end
  end
`else
  // NOTE: the array carries no reset so it maps onto block RAM; unwritten words hold their power-up value.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[addr_i] <= wdata_i;
    end
  end
`endif

  assign rdata_o = mem_q[addr_i];

endmodule : data_sram_mem

// File: rtl/data_sram_128x8.sv
// 128x8 single-port SRAM: active-low chip select, write-first reads, registered DOUT.
// DATA_SRAM_CLR_EN: when defined, reset also clears the storage array.
module data_sram_128x8 #(
  parameter int DATA_W = data_sram_pkg::DATA_W,
  parameter int ADDR_W = data_sram_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              CS_D,
  input  logic              WD,
  input  logic              RD,
  input  logic [DATA_W-1:0] DIN,
  input  logic [ADDR_W-1:0] ADDR,
  output logic [DATA_W-1:0] DOUT
);

  logic              wr_en;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] dout_d;
  logic [DATA_W-1:0] dout_q;

  assign wr_en = ~CS_D & WD;
  assign rd_en = ~CS_D & RD;

  data_sram_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (wr_en),
    .addr_i  (ADDR),
    .wdata_i (DIN),
    .rdata_o (rd_data)
  );

  // NOTE: default assignment first so no path through this block can infer a latch.
  always_comb begin
    dout_d = dout_q;
    if (rd_en) begin
      dout_d = wr_en ? DIN : rd_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= '0;
    end else begin
      dout_q <= dout_d;
    end
  end

  assign DOUT = dout_q;

endmodule : data_sram_128x8

// File: tb/tb_data_sram_128x8.sv
// Directed self-checking bench for data_sram_128x8; expectations follow DATA_SRAM_CLR_EN.
module tb_data_sram_128x8;
  import data_sram_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        CS_D;
  logic        WD;
  logic        RD;
  word_t       DIN;
  logic [6:0]  ADDR;
  word_t       DOUT;

  int checks_total  = 0;
  int checks_passed = 0;

  data_sram_128x8 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .CS_D  (CS_D),
    .WD    (WD),
    .RD    (RD),
    .DIN   (DIN),
    .ADDR  (ADDR),
    .DOUT  (DOUT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input word_t got, input word_t exp);
    checks_total++;
    if (got === exp) begin
      checks_passed++;
    end else begin
      $display("FAIL %s: got 0x%02h, want 0x%02h", tag, got, exp);
    end
  endtask

  // Drive one access at the falling edge, let one rising edge act on it, return at the next falling edge.
  task automatic access(input logic cs_n, input logic wd, input logic rd,
                        input logic [6:0] addr, input word_t din);
    CS_D = cs_n;
    WD   = wd;
    RD   = rd;
    ADDR = addr;
    DIN  = din;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic write(input logic [6:0] addr, input word_t din);
    access(1'b0, 1'b1, 1'b0, addr, din);
  endtask

  task automatic read(input logic [6:0] addr);
    access(1'b0, 1'b0, 1'b1, addr, 8'h00);
  endtask

  task automatic idle();
    access(1'b1, 1'b0, 1'b0, 7'h00, 8'h00);
  endtask

  initial begin
    word_t exp_a1;
    word_t exp_a7f;
`ifdef DATA_SRAM_CLR_EN
    exp_a1  = 8'h00;
    exp_a7f = 8'h00;
`else
    exp_a1  = 8'h03;
    exp_a7f = 8'hA5;
`endif

    rst_n = 1'b1;
    CS_D  = 1'b1;
    WD    = 1'b0;
    RD    = 1'b0;
    DIN   = 8'h00;
    ADDR  = 7'h00;

    // Reset asserted between edges must clear DOUT without a clock edge.
    #12;
    rst_n = 1'b0;
    #1;
    check("reset_async", DOUT, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    check("idle_after_reset", DOUT, 8'h00);

    write(7'h00, 8'h01);
    check("write_no_rd_dout", DOUT, 8'h00);
    write(7'h01, 8'h03);
    read(7'h00);
    check("read_a0", DOUT, 8'h01);
    read(7'h01);
    check("read_a1", DOUT, 8'h03);

    access(1'b1, 1'b1, 1'b0, 7'h00, 8'hFF);
    read(7'h00);
    check("deselect_write_blocked", DOUT, 8'h01);

    access(1'b0, 1'b1, 1'b1, 7'h7F, 8'hA5);
    check("write_first", DOUT, 8'hA5);
    read(7'h01);
    check("read_a1_again", DOUT, 8'h03);
    read(7'h7F);
    check("read_a7f", DOUT, 8'hA5);

    // Distinct addresses must not alias onto each other.
    write(7'h40, 8'h5A);
    write(7'h2A, 8'h77);
    read(7'h00);
    check("no_alias_a0", DOUT, 8'h01);
    read(7'h40);
    check("read_a40", DOUT, 8'h5A);
    read(7'h2A);
    check("read_a2a", DOUT, 8'h77);
    read(7'h7F);
    check("no_alias_a7f", DOUT, 8'hA5);

    read(7'h01);
    check("hold_setup", DOUT, 8'h03);
    for (int i = 0; i < 5; i++) begin
      access(1'b1, 1'b0, 1'b1, 7'h00, 8'h00);
      check($sformatf("hold_cs_high_%0d", i), DOUT, 8'h03);
    end
    access(1'b0, 1'b0, 1'b0, 7'h00, 8'h00);
    check("hold_rd_low", DOUT, 8'h03);

    // Reset in the middle of a write to addr 1: DOUT clears at once, the write is lost.
    CS_D = 1'b0;
    WD   = 1'b1;
    RD   = 1'b1;
    ADDR = 7'h01;
    DIN  = 8'hEE;
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_mid_access", DOUT, 8'h00);
    @(posedge clk);
    @(negedge clk);
    check("reset_held_dout", DOUT, 8'h00);
    rst_n = 1'b1;
    idle();
    check("resume_idle", DOUT, 8'h00);
    read(7'h01);
    check("post_reset_a1", DOUT, exp_a1);
    read(7'h7F);
    check("post_reset_a7f", DOUT, exp_a7f);

    write(7'h01, 8'h3C);
    read(7'h01);
    check("resume_write_read", DOUT, 8'h3C);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule : tb_data_sram_128x8
